// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM bank: default geometry, reset
// level/period and the channel-select width helper.
package pwm_pkg;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_WIDTH       = 4;
   localparam int DEF_INIT_LEVEL  = 5;
   localparam int DEF_INIT_PERIOD = 10;

   typedef logic [DEF_WIDTH-1:0] level_t;

   // A one-channel bank still needs a 1-bit select field.
   function automatic int chan_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Host-side bundle for pwm_bank: period, step buttons and level writes go in,
// PWM outputs and the period-start pulse come back.
interface pwm_bank_if
   import pwm_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH
) ();

   localparam int CW = chan_bits(CHANNELS);

   // load_valid qualifies load_ch/load_level in exactly the cycle it is high.
   // There is no ready: the bank accepts every write on the next rising edge.
   logic [WIDTH-1:0]    period;
   logic [CHANNELS-1:0] step;
   logic                load_valid;
   logic [CW-1:0]       load_ch;
   logic [WIDTH-1:0]    load_level;
   logic [CHANNELS-1:0] out;
   logic                cycle_start;

   modport master (
      output period, step, load_valid, load_ch, load_level,
      input  out, cycle_start
   );

   modport slave (
      input  period, step, load_valid, load_ch, load_level,
      output out, cycle_start
   );

endinterface

// File: rtl/pwm_step_sync.sv
// One button line: two-flop synchronizer followed by a rising-edge detector
// that yields a single-cycle pulse per press.
module pwm_step_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic meta, sync, sync_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise = sync & ~sync_d;

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one period counter; each channel has a pending
// level (written by loads/steps) that becomes active only at a period wrap.
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int INIT_LEVEL  = DEF_INIT_LEVEL,
   parameter int INIT_PERIOD = DEF_INIT_PERIOD
) (
   input logic       in,
   input logic       rst,
   pwm_bank_if.slave bus
);

   logic [WIDTH-1:0]    cnt;
   logic [WIDTH-1:0]    active_period;
   logic [WIDTH-1:0]    pending     [CHANNELS];
   logic [WIDTH-1:0]    pending_nxt [CHANNELS];
   logic [WIDTH-1:0]    active      [CHANNELS];
   logic [CHANNELS-1:0] step_rise;
   logic [CHANNELS-1:0] out_q;
   logic                cs_q;
   logic                run;
   logic                wrap;

   // The guard keeps lvl+1 inside WIDTH bits and handles period 0 without underflow.
   function automatic logic [WIDTH-1:0] step_level(input logic [WIDTH-1:0] lvl,
                                                   input logic [WIDTH-1:0] per);
      if ((per != '0) && (lvl < per - WIDTH'(1))) return lvl + WIDTH'(1);
      return '0;
   endfunction

   for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
      pwm_step_sync u_sync (
         .clk  (in),
         .rst  (rst),
         .din  (bus.step[g]),
         .rise (step_rise[g])
      );
   end

   // A stopped counter (period 0) wraps every cycle so a new period is picked up.
   assign run  = (active_period != '0);
   assign wrap = !run || (cnt == active_period - WIDTH'(1));

   // Matching against i also rejects any out-of-range channel select.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pending_nxt[i] = pending[i];
         if (bus.load_valid && (int'(bus.load_ch) == i))
            pending_nxt[i] = bus.load_level;
         else if (step_rise[i])
            pending_nxt[i] = step_level(pending[i], bus.period);
      end
   end

   // cycle_start is registered alongside out so both mark the same period start.
   always_ff @(posedge in) begin
      if (rst) begin
         cnt           <= '0;
         active_period <= WIDTH'(INIT_PERIOD);
         out_q         <= '0;
         cs_q          <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            pending[i] <= WIDTH'(INIT_LEVEL);
            active[i]  <= WIDTH'(INIT_LEVEL);
         end
      end else begin
         cnt  <= wrap ? '0 : cnt + WIDTH'(1);
         cs_q <= run && (cnt == '0);
         if (wrap) active_period <= bus.period;
         for (int i = 0; i < CHANNELS; i++) begin
            out_q[i]   <= run && (cnt < active[i]);
            pending[i] <= pending_nxt[i];
            if (wrap) active[i] <= pending[i];
         end
      end
   end

   assign bus.out         = out_q;
   assign bus.cycle_start = cs_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: duty and period are measured per PWM period
// between cycle_start pulses and compared with hand-computed values.
module tb_pwm_bank;
   import pwm_pkg::*;

   localparam int CH = 4;
   localparam int W  = 4;

   logic clk = 1'b0;
   logic rst;

   pwm_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   pwm_bank #(
      .CHANNELS(CH), .WIDTH(W), .INIT_LEVEL(5), .INIT_PERIOD(10)
   ) dut (
      .in  (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int m_len;
   int m_hi [CH];
   logic [W-1:0] exp_q [$];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cs();
      int budget = 40;
      while ((bus.cycle_start !== 1'b1) && (budget > 0)) begin
         @(negedge clk);
         budget--;
      end
      if (bus.cycle_start !== 1'b1) begin
         errors++; checks++;
         $display("FAIL wait_cs: cycle_start=%b, required 1 within 40 cycles", bus.cycle_start);
      end
   endtask

   // Counts cycles and per-channel high cycles from one cycle_start to the next.
   task automatic measure();
      wait_cs();
      m_len = 0;
      for (int i = 0; i < CH; i++) m_hi[i] = 0;
      do begin
         m_len++;
         for (int i = 0; i < CH; i++) if (bus.out[i] === 1'b1) m_hi[i]++;
         @(negedge clk);
      end while ((bus.cycle_start !== 1'b1) && (m_len < 40));
   endtask

   task automatic load(input int ch, input int lvl);
      bus.load_valid = 1'b1;
      bus.load_ch    = 2'(ch);
      bus.load_level = W'(lvl);
      tick(1);
      bus.load_valid = 1'b0;
   endtask

   task automatic pulse_step(input int ch);
      bus.step[ch] = 1'b1;
      tick(2);
      bus.step[ch] = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.period = 4'd10; bus.step = '0;
      bus.load_valid = 1'b0; bus.load_ch = '0; bus.load_level = '0;
      tick(2);
      checks++;
      if (bus.out !== 4'h0) begin errors++; $display("FAIL reset_out: got %b, required 0000", bus.out); end
      checks++;
      if (bus.cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b, required 0", bus.cycle_start); end
      rst = 1'b0;
      tick(1);
      checks++;
      if (bus.cycle_start !== 1'b1) begin errors++; $display("FAIL first_cs: got %b, required 1", bus.cycle_start); end
      checks++;
      if (bus.out !== 4'hF) begin errors++; $display("FAIL first_out: got %b, required 1111", bus.out); end
   endtask

   task automatic test_default_duty();
      repeat (2) begin
         measure();
         checks++;
         if (m_len !== 10) begin errors++; $display("FAIL default_len: got %0d, required 10", m_len); end
         for (int i = 0; i < CH; i++) begin
            checks++;
            if (m_hi[i] !== 5) begin errors++; $display("FAIL default_duty ch%0d: got %0d, required 5", i, m_hi[i]); end
         end
      end
   endtask

   task automatic test_step();
      level_t lvl = 4'd5;
      logic [W-1:0] exp;
      repeat (6) begin
         lvl = (lvl < 4'd9) ? lvl + 4'd1 : 4'd0;
         exp_q.push_back(lvl);
      end
      wait_cs();
      for (int k = 0; k < 6; k++) begin
         pulse_step(1);
         measure();
         exp = exp_q.pop_front();
         checks++;
         if (m_hi[1] !== int'(exp)) begin
            errors++; $display("FAIL step_duty #%0d: got %0d, required %0d", k, m_hi[1], exp);
         end
      end
      checks++;
      if (m_hi[0] !== 5) begin errors++; $display("FAIL step_other_ch: got %0d, required 5", m_hi[0]); end
   endtask

   task automatic test_load_extremes();
      load(2, 0);
      load(3, 15);
      repeat (2) begin
         measure();
         checks++;
         if (m_hi[2] !== 0) begin errors++; $display("FAIL level0_low: got %0d, required 0", m_hi[2]); end
         checks++;
         if (m_hi[3] !== 10) begin errors++; $display("FAIL level15_high: got %0d, required 10", m_hi[3]); end
      end
      // Load sampled on the wrap edge itself: old level for one more period.
      tick(8);
      load(0, 7);
      measure();
      checks++;
      if (m_hi[0] !== 5) begin errors++; $display("FAIL wrap_load_old: got %0d, required 5", m_hi[0]); end
      measure();
      checks++;
      if (m_hi[0] !== 7) begin errors++; $display("FAIL wrap_load_new: got %0d, required 7", m_hi[0]); end
   endtask

   task automatic test_back_to_back();
      // Step edge on ch0 is detected in the same cycle the load is presented.
      bus.step[0] = 1'b1;
      tick(2);
      bus.load_valid = 1'b1; bus.load_ch = 2'd0; bus.load_level = 4'd3;
      tick(1);
      bus.load_valid = 1'b0; bus.step[0] = 1'b0;
      tick(1);
      measure();
      checks++;
      if (m_hi[0] !== 3) begin errors++; $display("FAIL load_beats_step: got %0d, required 3", m_hi[0]); end
      bus.step[1] = 1'b1;
      tick(2);
      bus.load_valid = 1'b1; bus.load_ch = 2'd2; bus.load_level = 4'd7;
      tick(1);
      bus.load_valid = 1'b0; bus.step[1] = 1'b0;
      tick(1);
      measure();
      checks++;
      if (m_hi[1] !== 2) begin errors++; $display("FAIL split_step_ch1: got %0d, required 2", m_hi[1]); end
      checks++;
      if (m_hi[2] !== 7) begin errors++; $display("FAIL split_load_ch2: got %0d, required 7", m_hi[2]); end
   endtask

   task automatic test_period_change();
      int exp10 [CH] = '{3, 2, 7, 10};
      int exp4  [CH] = '{3, 2, 4, 4};
      int out_ones = 0;
      int cs_ones  = 0;
      bus.period = 4'd4;
      measure();
      checks++;
      if (m_len !== 10) begin errors++; $display("FAIL period_keep_len: got %0d, required 10", m_len); end
      for (int i = 0; i < CH; i++) begin
         checks++;
         if (m_hi[i] !== exp10[i]) begin errors++; $display("FAIL period_keep_duty ch%0d: got %0d, required %0d", i, m_hi[i], exp10[i]); end
      end
      measure();
      checks++;
      if (m_len !== 4) begin errors++; $display("FAIL period_new_len: got %0d, required 4", m_len); end
      for (int i = 0; i < CH; i++) begin
         checks++;
         if (m_hi[i] !== exp4[i]) begin errors++; $display("FAIL period_new_duty ch%0d: got %0d, required %0d", i, m_hi[i], exp4[i]); end
      end
      bus.period = 4'd0;
      tick(6);
      repeat (8) begin
         if (bus.out !== 4'h0) out_ones++;
         if (bus.cycle_start !== 1'b0) cs_ones++;
         tick(1);
      end
      checks++;
      if (out_ones !== 0) begin errors++; $display("FAIL period0_out: got %0d active cycles, required 0", out_ones); end
      checks++;
      if (cs_ones !== 0) begin errors++; $display("FAIL period0_cs: got %0d pulses, required 0", cs_ones); end
   endtask

   task automatic test_reset_mid();
      bus.period = 4'd10;
      wait_cs();
      tick(1);
      load(3, 1);
      tick(3);
      checks++;
      if (bus.out !== 4'b1100) begin errors++; $display("FAIL pre_reset_out: got %b, required 1100", bus.out); end
      rst = 1'b1;
      tick(1);
      checks++;
      if (bus.out !== 4'h0) begin errors++; $display("FAIL midreset_out: got %b, required 0000", bus.out); end
      checks++;
      if (bus.cycle_start !== 1'b0) begin errors++; $display("FAIL midreset_cs: got %b, required 0", bus.cycle_start); end
      rst = 1'b0;
      tick(1);
      checks++;
      if (bus.cycle_start !== 1'b1) begin errors++; $display("FAIL postreset_cs: got %b, required 1", bus.cycle_start); end
      measure();
      checks++;
      if (m_len !== 10) begin errors++; $display("FAIL postreset_len: got %0d, required 10", m_len); end
      for (int i = 0; i < CH; i++) begin
         checks++;
         if (m_hi[i] !== 5) begin errors++; $display("FAIL postreset_duty ch%0d: got %0d, required 5", i, m_hi[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_default_duty();
      test_step();
      test_load_extremes();
      test_back_to_back();
      test_period_change();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
